// File: rtl/qos_drain_scheduler.sv
`default_nettype none
// qos_drain_scheduler: periodic drain of four QoS buffers, strict priority 1>2>3>4 with buffer-4 anti-starvation.
// Rev 1.0
module qos_drain_scheduler #(
  parameter int DRAIN_PERIOD = 150_000_000,
  parameter int TMR_W        = 28,
  parameter int OCC_W        = 3,
  parameter int PKT_W        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock_50,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [OCC_W-1:0]  occ1,
  input  logic [OCC_W-1:0]  occ2,
  input  logic [OCC_W-1:0]  occ3,
  input  logic [OCC_W-1:0]  occ4,
  input  logic [PKT_W-1:0]  head1,
  input  logic [PKT_W-1:0]  head2,
  input  logic [PKT_W-1:0]  head3,
  input  logic [PKT_W-1:0]  head4,
  output logic [3:0]        pop,
  output logic              out_valid,
  output logic [PKT_W-1:0]  out_packet,
  output logic [3:0]        out_buffer,
  output logic [11:0]       output_count1,
  output logic [11:0]       output_count2,
  output logic [11:0]       output_count3,
  output logic [11:0]       output_count4,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SELECT = 2'd2;
  localparam logic [1:0] S_POP    = 2'd3;

  localparam int              SC_W     = (STARVE_LIMIT < 3) ? 2 : $clog2(STARVE_LIMIT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_PERIOD - 1);
  localparam logic [SC_W-1:0]  SC_LIMIT = SC_W'(STARVE_LIMIT);
  localparam logic [11:0]      CNT_MAX  = 12'hFFF;

  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic [SC_W-1:0]  r_starve;
  logic [PKT_W-1:0] r_packet;
  logic [3:0]       r_buffer;
  logic [11:0]      r_cnt [4];

  logic [3:0]       w_nz;
  logic [3:0]       w_grant;
  logic [PKT_W-1:0] w_head;
  logic [SC_W-1:0]  w_starve_nxt;

  assign w_nz = {occ4 != '0, occ3 != '0, occ2 != '0, occ1 != '0};

  // Anti-starvation override takes precedence over the fixed priority order.
  always_comb begin
    w_grant = 4'b0000;
    w_head  = '0;
    if (w_nz[3] && (r_starve == SC_LIMIT)) begin
      w_grant = 4'b1000;
      w_head  = head4;
    end else if (w_nz[0]) begin
      w_grant = 4'b0001;
      w_head  = head1;
    end else if (w_nz[1]) begin
      w_grant = 4'b0010;
      w_head  = head2;
    end else if (w_nz[2]) begin
      w_grant = 4'b0100;
      w_head  = head3;
    end else if (w_nz[3]) begin
      w_grant = 4'b1000;
      w_head  = head4;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!w_nz[3] || w_grant[3]) begin
      w_starve_nxt = '0;
    end else if ((w_grant != 4'b0000) && (r_starve != SC_LIMIT)) begin
      w_starve_nxt = r_starve + SC_W'(1);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_starve <= '0;
      r_packet <= '0;
      r_buffer <= 4'b0000;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (enable) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end else if (r_timer == TMR_LAST) begin
            r_timer <= '0;
            r_state <= S_SELECT;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_SELECT: begin
          // Timer keeps running so the drain cadence does not drift.
          r_timer  <= r_timer + TMR_W'(1);
          r_starve <= w_starve_nxt;
          if (w_grant != 4'b0000) begin
            r_packet <= w_head;
            r_buffer <= w_grant;
            for (int i = 0; i < 4; i++) begin
              if (w_grant[i] && (r_cnt[i] != CNT_MAX)) r_cnt[i] <= r_cnt[i] + 12'd1;
            end
            r_state <= S_POP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_POP: begin
          r_timer <= r_timer + TMR_W'(1);
          r_state <= S_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pop           = (r_state == S_POP) ? r_buffer : 4'b0000;
  assign out_valid     = (r_state == S_POP);
  assign out_packet    = r_packet;
  assign out_buffer    = r_buffer;
  assign output_count1 = r_cnt[0];
  assign output_count2 = r_cnt[1];
  assign output_count3 = r_cnt[2];
  assign output_count4 = r_cnt[3];
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire
